// File: rtl/ama_riscv_alu_dec_pkg.sv
// Shared ALU decode definitions: ALU op codes, RV32I opcodes, operand-select and immediate-type enums.
package ama_riscv_alu_dec_pkg;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic {A_RS1 = 1'b0, A_PC  = 1'b1} a_sel_e;
  typedef enum logic {B_RS2 = 1'b0, B_IMM = 1'b1} b_sel_e;
  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

  typedef struct packed {
    logic [3:0] op_sel;
    a_sel_e     a_sel;
    b_sel_e     b_sel;
    imm_type_e  imm_type;
    logic       illegal;
  } dec_t;

  localparam dec_t DEC_ILLEGAL = '{op_sel: ALU_ADD, a_sel: A_RS1, b_sel: B_RS2,
                                   imm_type: IMM_NONE, illegal: 1'b1};

  function automatic dec_t mk_dec(input logic [3:0] op, input a_sel_e a, input b_sel_e b,
                                  input imm_type_e t);
    mk_dec = '{op_sel: op, a_sel: a, b_sel: b, imm_type: t, illegal: 1'b0};
  endfunction

  // alt selects SUB/SRA on the f3 codes that have an alternate form
  function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_to_alu = alt ? ALU_SUB : ALU_ADD;
      3'b001:  f3_to_alu = ALU_SLL;
      3'b010:  f3_to_alu = ALU_SLT;
      3'b011:  f3_to_alu = ALU_SLTU;
      3'b100:  f3_to_alu = ALU_XOR;
      3'b101:  f3_to_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  f3_to_alu = ALU_OR;
      default: f3_to_alu = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ama_riscv_imm_gen.sv
// Combinational RV32I immediate generator; all formats sign-extend from instr[31].
module ama_riscv_imm_gen
  import ama_riscv_alu_dec_pkg::*;
#(
  parameter int IMM_W = 32
) (
  input  logic [31:7]      instr,
  input  imm_type_e        imm_type,
  output logic [IMM_W-1:0] imm
);

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = 32'h0;
    case (imm_type)
      IMM_I:   w_imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   w_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   w_imm32 = {instr[31:12], 12'h0};
      IMM_J:   w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: w_imm32 = 32'h0;
    endcase
  end

  assign imm = IMM_W'($signed(w_imm32));

endmodule

// File: rtl/ama_riscv_alu_dec.sv
// ID->EX decode stage: RV32I instruction to ALU op/operand selects/immediate, held in a
// single valid/ready register slot with flush.
module ama_riscv_alu_dec
  import ama_riscv_alu_dec_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IMM_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr_in,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       op_sel,
  output logic             a_sel,
  output logic             b_sel,
  output logic [IMM_W-1:0] imm,
  output logic [PC_W-1:0]  pc_out,
  output logic             illegal
);

  logic [6:0]       w_opc;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  dec_t             w_dec;
  logic [IMM_W-1:0] w_imm;
  logic             w_load;

  logic             r_out_valid;
  logic [3:0]       r_op_sel;
  logic             r_a_sel;
  logic             r_b_sel;
  logic [IMM_W-1:0] r_imm;
  logic [PC_W-1:0]  r_pc;
  logic             r_illegal;

  assign w_opc = instr_in[6:0];
  assign w_f3  = instr_in[14:12];
  assign w_f7  = instr_in[31:25];

  always_comb begin
    w_dec = DEC_ILLEGAL;
    if (instr_in[1:0] == 2'b11) begin
      case (w_opc)
        OPC_OP:
          if (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)))
            w_dec = mk_dec(f3_to_alu(w_f3, w_f7[5]), A_RS1, B_RS2, IMM_NONE);
        OPC_OP_IMM:
          // no SUBI; f7 only qualifies the shift encodings
          if ((w_f3 != 3'b001 && w_f3 != 3'b101) ||
              (w_f3 == 3'b001 && w_f7 == 7'h00) ||
              (w_f3 == 3'b101 && (w_f7 == 7'h00 || w_f7 == 7'h20)))
            w_dec = mk_dec(f3_to_alu(w_f3, (w_f3 == 3'b101) && w_f7[5]), A_RS1, B_IMM, IMM_I);
        OPC_LUI:    w_dec = mk_dec(ALU_PASS_B, A_RS1, B_IMM, IMM_U);
        OPC_AUIPC:  w_dec = mk_dec(ALU_ADD, A_PC, B_IMM, IMM_U);
        OPC_JAL:    w_dec = mk_dec(ALU_ADD, A_PC, B_IMM, IMM_J);
        OPC_JALR:
          if (w_f3 == 3'b000) w_dec = mk_dec(ALU_ADD, A_RS1, B_IMM, IMM_I);
        OPC_LOAD:   w_dec = mk_dec(ALU_ADD, A_RS1, B_IMM, IMM_I);
        OPC_STORE:  w_dec = mk_dec(ALU_ADD, A_RS1, B_IMM, IMM_S);
        OPC_BRANCH:
          if (w_f3 != 3'b010 && w_f3 != 3'b011) w_dec = mk_dec(ALU_ADD, A_PC, B_IMM, IMM_B);
        default:    w_dec = DEC_ILLEGAL;
      endcase
    end
  end

  ama_riscv_imm_gen #(.IMM_W(IMM_W)) u_imm_gen (
    .instr    (instr_in[31:7]),
    .imm_type (w_dec.imm_type),
    .imm      (w_imm)
  );

  assign in_ready = !r_out_valid || out_ready;
  assign w_load   = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_op_sel    <= ALU_ADD;
      r_a_sel     <= 1'b0;
      r_b_sel     <= 1'b0;
      r_imm       <= '0;
      r_pc        <= '0;
      r_illegal   <= 1'b0;
    end else begin
      if (flush)         r_out_valid <= 1'b0;
      else if (in_ready) r_out_valid <= in_valid;
      // data regs only move on a real load; flush leaves them stale
      if (w_load) begin
        r_op_sel  <= w_dec.op_sel;
        r_a_sel   <= w_dec.a_sel;
        r_b_sel   <= w_dec.b_sel;
        r_imm     <= w_imm;
        r_pc      <= pc_in;
        r_illegal <= w_dec.illegal;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign op_sel    = r_op_sel;
  assign a_sel     = r_a_sel;
  assign b_sel     = r_b_sel;
  assign imm       = r_imm;
  assign pc_out    = r_pc;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_ama_riscv_alu_dec.sv
// Directed bench for ama_riscv_alu_dec: decode vector table plus handshake/flush/reset sequences.
module tb_ama_riscv_alu_dec;
  import ama_riscv_alu_dec_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr_in = 32'h0;
  logic [31:0] pc_in = 32'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  op_sel;
  logic        a_sel;
  logic        b_sel;
  logic [31:0] imm;
  logic [31:0] pc_out;
  logic        illegal;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ama_riscv_alu_dec #(.PC_W(32), .IMM_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instr_in(instr_in), .pc_in(pc_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .op_sel(op_sel), .a_sel(a_sel), .b_sel(b_sel),
    .imm(imm), .pc_out(pc_out), .illegal(illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  op;
    logic        a;
    logic        b;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] instr, input logic [3:0] op, input logic a,
                     input logic b, input logic [31:0] im, input logic ill);
    vec_t v;
    v.instr = instr; v.op = op; v.a = a; v.b = b; v.imm = im; v.ill = ill;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // all observable outputs packed: {out_valid, op_sel, a_sel, b_sel, illegal, imm, pc_out}
  function automatic logic [95:0] obs();
    obs = {24'h0, out_valid, op_sel, a_sel, b_sel, illegal, imm, pc_out};
  endfunction

  function automatic logic [95:0] mk(input logic v, input logic [3:0] op, input logic a,
                                     input logic b, input logic ill, input logic [31:0] im,
                                     input logic [31:0] pc);
    mk = {24'h0, v, op, a, b, ill, im, pc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ADD/SUB/shifts/logic on OP, then OP-IMM, U/J, loads/stores, branches, illegals
    add(32'h002081B3, ALU_ADD,    0, 0, 32'h0,        0);
    add(32'h402081B3, ALU_SUB,    0, 0, 32'h0,        0);
    add(32'h002091B3, ALU_SLL,    0, 0, 32'h0,        0);
    add(32'h0020B1B3, ALU_SLTU,   0, 0, 32'h0,        0);
    add(32'h4020D1B3, ALU_SRA,    0, 0, 32'h0,        0);
    add(32'h0020F1B3, ALU_AND,    0, 0, 32'h0,        0);
    add(32'h022081B3, ALU_ADD,    0, 0, 32'h0,        1);
    add(32'h4030D093, ALU_SRA,    0, 1, 32'h403,      0);
    add(32'hFFF00093, ALU_ADD,    0, 1, 32'hFFFFFFFF, 0);
    add(32'h40309093, ALU_ADD,    0, 0, 32'h0,        1);
    add(32'hABCDE0B7, ALU_PASS_B, 0, 1, 32'hABCDE000, 0);
    add(32'h12345297, ALU_ADD,    1, 1, 32'h12345000, 0);
    add(32'hFFFFF06F, ALU_ADD,    1, 1, 32'hFFFFFFFE, 0);
    add(32'h004100E7, ALU_ADD,    0, 1, 32'h4,        0);
    add(32'h004110E7, ALU_ADD,    0, 0, 32'h0,        1);
    add(32'hFFC12083, ALU_ADD,    0, 1, 32'hFFFFFFFC, 0);
    add(32'h00512423, ALU_ADD,    0, 1, 32'h8,        0);
    add(32'hFE002FA3, ALU_ADD,    0, 1, 32'hFFFFFFFF, 0);
    add(32'hFE000CE3, ALU_ADD,    1, 1, 32'hFFFFFFF8, 0);
    add(32'hFE002CE3, ALU_ADD,    0, 0, 32'h0,        1);
    add(32'h00000000, ALU_ADD,    0, 0, 32'h0,        1);
    add(32'h002081B1, ALU_ADD,    0, 0, 32'h0,        1);
    add(32'h0000000F, ALU_ADD,    0, 0, 32'h0,        1);

    #1;
    chk("reset_outputs", obs(), mk(0, ALU_ADD, 0, 0, 0, 32'h0, 32'h0));
    chk("reset_in_ready", {95'h0, in_ready}, 96'h1);
    step();
    rst = 1'b0;

    // back-to-back stream with out_ready=1: one result per cycle, no bubbles
    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = 1'b1;
      instr_in = vecs[i].instr;
      pc_in    = 32'h1000 + 32'(i * 4);
      step();
      chk($sformatf("vec%0d_%h", i, vecs[i].instr), obs(),
          mk(1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ill, vecs[i].imm, 32'h1000 + 32'(i * 4)));
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", {95'h0, out_valid}, 96'h0);

    // backpressure: A held for 3 cycles while B waits, then B loads exactly once
    in_valid = 1'b1; instr_in = 32'h002081B3; pc_in = 32'h40;
    step();
    out_ready = 1'b0;
    instr_in = 32'h402081B3; pc_in = 32'h44;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("stall%0d_in_ready", c), {95'h0, in_ready}, 96'h0);
      chk($sformatf("stall%0d_hold", c), obs(), mk(1, ALU_ADD, 0, 0, 0, 32'h0, 32'h40));
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {95'h0, in_ready}, 96'h1);
    step();
    chk("release_load_b", obs(), mk(1, ALU_SUB, 0, 0, 0, 32'h0, 32'h44));
    in_valid = 1'b0;
    step();
    chk("release_no_dup", {95'h0, out_valid}, 96'h0);

    // flush with an accepted input: nothing appears
    in_valid = 1'b1; flush = 1'b1; instr_in = 32'h12345297; pc_in = 32'h100;
    step();
    chk("flush_load", {95'h0, out_valid}, 96'h0);
    flush = 1'b0;
    step();
    chk("post_flush_load", obs(), mk(1, ALU_ADD, 1, 1, 0, 32'h12345000, 32'h100));

    // flush kills a stalled entry too
    out_ready = 1'b0; in_valid = 1'b0; flush = 1'b1;
    step();
    chk("flush_held", {95'h0, out_valid}, 96'h0);
    flush = 1'b0;

    // async reset in the middle of a stall
    in_valid = 1'b1; instr_in = 32'h4030D093; pc_in = 32'h200;
    step();
    chk("pre_rst_valid", obs(), mk(1, ALU_SRA, 0, 1, 0, 32'h403, 32'h200));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst", obs(), mk(0, ALU_ADD, 0, 0, 0, 32'h0, 32'h0));
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_idle", {95'h0, out_valid}, 96'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
